burst_capture_rx: RTL and testbench

// - Single-clock receiver for the 8-beat DDR data burst launched by the burst write transmitter.
// - Samples DataBus on posedge clock2x, qualified by toggles of the differential strobe DQS_t/DQS_c.
// - Assembles the beats into one host word and hands it over with a valid/ready handshake.
// - Detects a missing or stalled strobe and reports an error. Used on the memory side (write

---
 rtl/ddr_xfer_pkg.sv | 15 +
 rtl/burst_capture_rx_if.sv | 35 +++
 rtl/dqs_edge_det.sv | 18 +
 rtl/burst_capture_rx.sv | 137 +++++++++++++
 tb/tb_burst_capture_rx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_xfer_pkg.sv
// Shared types and default geometry for the clock2x burst capture receiver.
package ddr_xfer_pkg;

  localparam int DDR_DATA_W    = 64;
  localparam int DDR_BURST_LEN = 8;
  localparam int DDR_TIMEOUT   = 16;
  localparam int DDR_MAX_GAP   = 2;
  localparam int BC4_LEN       = 4;

  typedef enum logic [1:0] {IDLE, WAIT_STROBE, CAPTURE, DONE} rx_state_e;

  typedef logic [$clog2(DDR_BURST_LEN)-1:0]          beat_idx_t;
  typedef logic [DDR_BURST_LEN-1:0][DDR_DATA_W-1:0]  burst_t;

endpackage

// File: rtl/burst_capture_rx_if.sv
// Strobe/data capture bus plus host-side valid/ready handover.
// The chop input exists only when BURST_CHOP_EN is defined.
interface burst_capture_rx_if #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8
);
  logic                             start;
  logic [DATA_W-1:0]                DataBus;
  logic                             DQS_t;
  logic                             DQS_c;
  logic [BURST_LEN-1:0][DATA_W-1:0] DataHost;
  logic                             data_valid;
  logic                             data_ready;
  logic                             busy;
  logic                             error;
`ifdef BURST_CHOP_EN
  logic                             chop;
`endif

  modport master (
`ifdef BURST_CHOP_EN
    output chop,
`endif
    output start, DataBus, DQS_t, DQS_c, data_ready,
    input  DataHost, data_valid, busy, error
  );

  modport slave (
`ifdef BURST_CHOP_EN
    input  chop,
`endif
    input  start, DataBus, DQS_t, DQS_c, data_ready,
    output DataHost, data_valid, busy, error
  );
endinterface

// File: rtl/dqs_edge_det.sv
// Turns the differential strobe into a one-cycle beat qualifier: any toggle of
// the true leg while the pair is complementary.
module dqs_edge_det (
  input  logic clock2x,
  input  logic reset,
  input  logic dqs_t,
  input  logic dqs_c,
  output logic beat
);
  logic dqs_q;

  always_ff @(posedge clock2x) begin
    if (reset) dqs_q <= 1'b0;
    else       dqs_q <= dqs_t;
  end

  assign beat = (dqs_t != dqs_q) && (dqs_c == ~dqs_t);
endmodule

// File: rtl/burst_capture_rx.sv
// Captures one strobe-qualified DDR burst into DataHost and hands it to the host.
// Define BURST_CHOP_EN to add the chop input (4-beat bursts).
module burst_capture_rx
  import ddr_xfer_pkg::*;
#(
  parameter int DATA_W    = DDR_DATA_W,
  parameter int BURST_LEN = DDR_BURST_LEN,
  parameter int TIMEOUT   = DDR_TIMEOUT,
  parameter int MAX_GAP   = DDR_MAX_GAP
) (
  input  logic                clock2x,
  input  logic                reset,
  burst_capture_rx_if.slave   bus
);
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  rx_state_e                        state;
  logic [IDX_W-1:0]                 cnt;
  logic [IDX_W-1:0]                 last_idx;
  logic [TMR_W-1:0]                 timer;
  logic [GAP_W-1:0]                 gap;
  logic                             data_valid_q;
  logic                             busy_q;
  logic                             error_q;
  logic                             beat;
  logic                             last_beat;
  logic                             clr_host;
  logic                             wr_en;
  logic [BURST_LEN-1:0][DATA_W-1:0] host_q;

  dqs_edge_det u_edge (
    .clock2x (clock2x),
    .reset   (reset),
    .dqs_t   (bus.DQS_t),
    .dqs_c   (bus.DQS_c),
    .beat    (beat)
  );

`ifdef BURST_CHOP_EN
  logic chop_q;
  assign last_idx = chop_q ? IDX_W'(BC4_LEN - 1) : IDX_W'(BURST_LEN - 1);
`else
  assign last_idx = IDX_W'(BURST_LEN - 1);
`endif

  // cnt wraps after the final beat; termination comes from this flag, not cnt==0
  assign last_beat = (cnt == last_idx);

  always_comb begin
    clr_host = (state == IDLE) && bus.start;
    wr_en    = beat && ((state == WAIT_STROBE) || (state == CAPTURE));
  end

  always_ff @(posedge clock2x) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      timer        <= '0;
      gap          <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef BURST_CHOP_EN
      chop_q       <= 1'b0;
`endif
    end else begin
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= WAIT_STROBE;
            busy_q <= 1'b1;
            cnt    <= '0;
            timer  <= '0;
            gap    <= '0;
`ifdef BURST_CHOP_EN
            chop_q <= bus.chop;
`endif
          end
        end
        WAIT_STROBE, CAPTURE: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            gap <= '0;
            if (last_beat) begin
              state        <= DONE;
              busy_q       <= 1'b0;
              data_valid_q <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end else if (state == WAIT_STROBE) begin
            if (timer == TMR_W'(TIMEOUT - 1)) begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end else begin
            if (gap == GAP_W'(MAX_GAP - 1)) begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              error_q <= 1'b1;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end
        DONE: begin
          // start is ignored here, even on the handshake cycle
          if (bus.data_ready) begin
            state        <= IDLE;
            data_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < BURST_LEN; i++) begin : g_slot
    logic [DATA_W-1:0] slot_q;
    always_ff @(posedge clock2x) begin
      if (reset || clr_host)                 slot_q <= '0;
      else if (wr_en && cnt == IDX_W'(i))    slot_q <= bus.DataBus;
    end
    assign host_q[i] = slot_q;
  end

  assign bus.DataHost   = host_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.error      = error_q;
endmodule

// File: tb/tb_burst_capture_rx.sv
// Randomized scoreboard bench for burst_capture_rx; reference model works on
// the list of strobe beat positions rather than on cycle-level state.
module tb_burst_capture_rx;
  import ddr_xfer_pkg::*;

  localparam int DW = DDR_DATA_W;
  localparam int BL = DDR_BURST_LEN;
  localparam int TO = DDR_TIMEOUT;
  localparam int MG = DDR_MAX_GAP;
  localparam int K_IDLE = 0;
  localparam int K_BEAT = 1;
  localparam int K_BAD  = 2;

  logic clock2x = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   cur_t   = 1'b0;

  typedef struct { burst_t data; int cyc; } exp_t;
  exp_t exp_q[$];
  int   err_q[$];

  burst_capture_rx_if #(.DATA_W(DW), .BURST_LEN(BL)) bus ();

  burst_capture_rx #(.DATA_W(DW), .BURST_LEN(BL), .TIMEOUT(TO), .MAX_GAP(MG)) dut (
    .clock2x (clock2x),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock2x = ~clock2x;
  always @(posedge clock2x) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string name, input burst_t act, input burst_t exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock2x);
    #1;
  endtask

  // Outcome of one armed capture: which beat positions land in which slot,
  // or where the first timing rule is broken.
  function automatic void model(input int kinds[$], input logic [DW-1:0] data[$], input int n_len,
                                output bit is_err, output int end_k, output burst_t exp);
    int p[$];
    exp = '0;
    foreach (kinds[k]) if (kinds[k] == K_BEAT) p.push_back(k);
    if (p.size() == 0 || p[0] >= TO) begin
      is_err = 1'b1; end_k = TO - 1; return;
    end
    exp[0] = data[p[0]];
    for (int j = 1; j < n_len; j++) begin
      if (j >= p.size() || p[j] - p[j-1] - 1 >= MG) begin
        is_err = 1'b1; end_k = p[j-1] + MG; return;
      end
      exp[j] = data[p[j]];
    end
    is_err = 1'b0;
    end_k  = p[n_len-1];
  endfunction

  task automatic drive_kind(input int kind, input logic [DW-1:0] d);
    bus.DataBus = d;
    if (kind != K_IDLE) cur_t = ~cur_t;
    bus.DQS_t = cur_t;
    bus.DQS_c = (kind == K_BAD) ? cur_t : ~cur_t;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.data_valid) && n < 40) begin tick(); n++; end
    if (n >= 40) chk(!(bus.busy || bus.data_valid), "idle_wait_bound", burst_t'({bus.busy, bus.data_valid}), '0);
  endtask

  task automatic run_burst(input int kinds[$], input logic [DW-1:0] data[$], input bit chop,
                           input int rdy_dly, input bit poke_start);
    bit     is_err;
    int     end_k;
    int     s;
    burst_t exp;
    for (int i = 0; i < TO + MG; i++) begin
      kinds.push_back(K_IDLE);
      data.push_back({$urandom, $urandom});
    end
    model(kinds, data, chop ? BC4_LEN : BL, is_err, end_k, exp);
    wait_idle();
    bus.data_ready = (rdy_dly == 0);
`ifdef BURST_CHOP_EN
    bus.chop = chop;
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    s = cyc;
    chk(bus.busy == 1'b1, "busy_after_start", burst_t'(bus.busy), burst_t'(1));
    if (is_err) err_q.push_back(s + end_k + 1);
    else        exp_q.push_back('{exp, s + end_k + 1});
    for (int k = 0; k <= end_k; k++) drive_kind(kinds[k], data[k]);
    bus.DataBus = {$urandom, $urandom};
    if (!is_err) begin
      for (int i = 0; i < rdy_dly; i++) begin
        bus.start = poke_start && (i == 1);
        tick();
        bus.start = 1'b0;
      end
      bus.start      = poke_start;
      bus.data_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk(!bus.data_valid && !bus.busy, "idle_after_handshake",
          burst_t'({bus.data_valid, bus.busy}), '0);
    end else begin
      tick();
    end
  endtask

  task automatic mk_burst(input int nbeats, output int kinds[$], output logic [DW-1:0] data[$]);
    kinds.delete();
    data.delete();
    for (int i = 0; i < 2; i++) begin kinds.push_back(K_IDLE); data.push_back({$urandom, $urandom}); end
    for (int j = 0; j < nbeats; j++) begin
      logic [7:0] b;
      b = 8'h11 * 8'(j + 1);
      kinds.push_back(K_BEAT);
      data.push_back({8{b}});
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an outcome.
  bit     dv_prev, rdy_prev, err_prev;
  burst_t host_prev;
  always @(negedge clock2x) begin
    if (reset) begin
      dv_prev  = 1'b0;
      rdy_prev = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (bus.error) begin
        chk(!err_prev, "error_pulse_width", burst_t'(err_prev), '0);
        chk(err_q.size() != 0, "error_expected", burst_t'(bus.error), '0);
        if (err_q.size() != 0) begin
          int e;
          e = err_q.pop_front();
          chk(cyc == e, "error_cycle", burst_t'(cyc), burst_t'(e));
        end
      end
      if (bus.data_valid && !dv_prev) begin
        chk(exp_q.size() != 0, "valid_expected", burst_t'(bus.data_valid), '0);
        if (exp_q.size() != 0) begin
          exp_t x;
          x = exp_q.pop_front();
          chk(cyc == x.cyc, "valid_latency", burst_t'(cyc), burst_t'(x.cyc));
          chk(bus.DataHost == x.data, "data_host", bus.DataHost, x.data);
        end
      end else if (dv_prev && !rdy_prev) begin
        chk(bus.data_valid && bus.DataHost == host_prev, "hold_under_backpressure",
            bus.DataHost, host_prev);
      end
      dv_prev   = bus.data_valid;
      rdy_prev  = bus.data_ready;
      err_prev  = bus.error;
      host_prev = bus.DataHost;
    end
  end

  initial begin
    int               kinds[$];
    logic [DW-1:0]    data[$];
    bus.start      = 1'b0;
    bus.DataBus    = '0;
    bus.DQS_t      = 1'b0;
    bus.DQS_c      = 1'b1;
    bus.data_ready = 1'b1;
`ifdef BURST_CHOP_EN
    bus.chop = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk(bus.DataHost == '0, "reset_host", bus.DataHost, '0);
    chk(bus.data_valid == 1'b0, "reset_valid", burst_t'(bus.data_valid), '0);
    chk(bus.busy == 1'b0, "reset_busy", burst_t'(bus.busy), '0);
    chk(bus.error == 1'b0, "reset_error", burst_t'(bus.error), '0);

    // clean burst
    mk_burst(8, kinds, data);
    run_burst(kinds, data, 1'b0, 0, 1'b0);
    // backpressure with ignored starts
    mk_burst(8, kinds, data);
    run_burst(kinds, data, 1'b0, 5, 1'b1);
    // timeout: strobe never moves
    kinds.delete(); data.delete();
    run_burst(kinds, data, 1'b0, 0, 1'b0);
    // gap after beat 3, then a clean burst
    mk_burst(3, kinds, data);
    run_burst(kinds, data, 1'b0, 0, 1'b0);
    mk_burst(8, kinds, data);
    run_burst(kinds, data, 1'b0, 1, 1'b0);
    // non-complementary strobe mid-burst
    mk_burst(8, kinds, data);
    kinds.insert(6, K_BAD);
    data.insert(6, {$urandom, $urandom});
    run_burst(kinds, data, 1'b0, 0, 1'b0);

    // reset landing on beat 5
    wait_idle();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < 4; j++) drive_kind(K_BEAT, {$urandom, $urandom});
    reset = 1'b1;
    drive_kind(K_BEAT, {$urandom, $urandom});
    reset = 1'b0;
    chk(bus.DataHost == '0, "midreset_host", bus.DataHost, '0);
    chk(!bus.data_valid && !bus.busy && !bus.error, "midreset_flags",
        burst_t'({bus.data_valid, bus.busy, bus.error}), '0);
    tick();

`ifdef BURST_CHOP_EN
    mk_burst(4, kinds, data);
    run_burst(kinds, data, 1'b1, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      int pre;
      int body;
      int r;
      bit chop;
      kinds.delete();
      data.delete();
      pre = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 5);
      for (int i = 0; i < pre; i++) kinds.push_back(($urandom_range(0, 3) == 0) ? K_BAD : K_IDLE);
      body = $urandom_range(4, 14);
      for (int i = 0; i < body; i++) begin
        r = $urandom_range(0, 19);
        kinds.push_back(r < 14 ? K_BEAT : (r < 17 ? K_IDLE : K_BAD));
      end
      foreach (kinds[i]) data.push_back({$urandom, $urandom});
`ifdef BURST_CHOP_EN
      chop = 1'($urandom_range(0, 1));
`else
      chop = 1'b0;
`endif
      run_burst(kinds, data, chop, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) tick();
    chk(exp_q.size() == 0, "bursts_outstanding", burst_t'(exp_q.size()), '0);
    chk(err_q.size() == 0, "errors_outstanding", burst_t'(err_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
